// File: rtl/spike_dispatcher_if.sv
// FIFO read port and AER output bus between the spike dispatcher (master)
// and its FIFO / tinyODIN neighbours (slave).
interface spike_dispatcher_if #(
    parameter int M = 8
);
    logic         FIFO_r_en_o;
    logic [M-1:0] FIFO_r_data_i;
    logic         FIFO_empty_i;
    logic [2*M:0] AERIN_ADDR;
    logic         AERIN_REQ;
    logic         AERIN_ACK;

    modport master (
        output FIFO_r_en_o,
        output AERIN_ADDR,
        output AERIN_REQ,
        input  FIFO_r_data_i,
        input  FIFO_empty_i,
        input  AERIN_ACK
    );

    modport slave (
        input  FIFO_r_en_o,
        input  AERIN_ADDR,
        input  AERIN_REQ,
        output FIFO_r_data_i,
        output FIFO_empty_i,
        output AERIN_ACK
    );
endinterface

// File: rtl/spike_dispatcher.sv
// Drains the spike FIFO and hands each neuron index to tinyODIN as an AER
// event over a 4-phase req/ack handshake; counts events and flags tick end.
module spike_dispatcher #(
    parameter int           N        = 256,
    parameter int           M        = 8,
    parameter logic [M-1:0] EVT_CODE = 8'hFF
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  en_i,
    input  logic                  start_i,
    input  logic                  filter_done_i,
    spike_dispatcher_if.master    bus,
    output logic [$clog2(N):0]    evt_cnt_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_LOAD = 3'd2,
        ST_REQ  = 3'd3,
        ST_REL  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_evt_done;
    logic           w_done;
    logic           w_pend_eff;

    logic           r_ack_s1;
    logic           r_ack_s;
    logic           r_fifo_ren;
    logic           r_req;
    logic [2*M:0]   r_addr;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_pend;

    // ACK comes from another clock domain; only the second flop is trusted.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ack_s1 <= 1'b0;
            r_ack_s  <= 1'b0;
        end else begin
            r_ack_s1 <= bus.AERIN_ACK;
            r_ack_s  <= r_ack_s1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_evt_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en_i && !bus.FIFO_empty_i) begin
                    w_state_nxt = ST_POP;
                end
            end
            ST_POP:  w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (r_ack_s) begin
                    w_state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                if (!r_ack_s) begin
                    w_evt_done  = 1'b1;
                    w_state_nxt = (en_i && !bus.FIFO_empty_i) ? ST_POP : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state itself.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_fifo_ren <= 1'b0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_fifo_ren <= (w_state_nxt == ST_POP);
            r_req      <= (w_state_nxt == ST_REQ);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Address is held after the handshake; it only changes on the next LOAD.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_addr <= '0;
        end else if (r_state == ST_LOAD) begin
            r_addr <= {1'b0, bus.FIFO_r_data_i, EVT_CODE};
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt <= '0;
        end else if (start_i) begin
            r_cnt <= '0;
        end else if (w_evt_done && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A filter_done arriving while already idle and drained completes next cycle.
    assign w_pend_eff = r_pend || filter_done_i;
    assign w_done     = !start_i && w_pend_eff && (r_state == ST_IDLE) && bus.FIFO_empty_i;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_pend <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done;
            if (start_i || w_done) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= w_pend_eff;
            end
        end
    end

    assign bus.FIFO_r_en_o = r_fifo_ren;
    assign bus.AERIN_REQ   = r_req;
    assign bus.AERIN_ADDR  = r_addr;
    assign evt_cnt_o       = r_cnt;
    assign busy_o          = r_busy;
    assign done_o          = r_done;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: FIFO model, delayed-ack AER model,
// one task per scenario with inline comparisons.
module tb_spike_dispatcher;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       en_i;
    logic       start_i;
    logic       filter_done_i;
    logic [8:0] evt_cnt_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;

    spike_dispatcher_if #(.M(8)) bif ();

    spike_dispatcher #(.N(256), .M(8), .EVT_CODE(8'hFF)) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .en_i          (en_i),
        .start_i       (start_i),
        .filter_done_i (filter_done_i),
        .bus           (bif.master),
        .evt_cnt_o     (evt_cnt_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 CLK = ~CLK;

    // FIFO model: data valid the cycle after the pop strobe.
    logic [7:0] fmem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int n_pops = 0;
    int n_bad_pops = 0;
    assign bif.FIFO_empty_i = (wr_ptr == rd_ptr);

    always @(posedge CLK) begin
        if (bif.FIFO_r_en_o) begin
            n_pops <= n_pops + 1;
            if (rd_ptr != wr_ptr) begin
                bif.FIFO_r_data_i <= fmem[rd_ptr % 512];
                rd_ptr <= rd_ptr + 1;
            end else begin
                n_bad_pops <= n_bad_pops + 1;
            end
        end
    end

    // AER receiver: ack follows req two cycles later.
    logic [1:0] ack_dly = 2'b00;
    always @(posedge CLK) ack_dly <= {ack_dly[0], bif.AERIN_REQ};
    assign bif.AERIN_ACK = ack_dly[1];

    // Monitor for request edges and done pulses.
    logic [16:0] addr_log [0:511];
    int n_req = 0;
    int n_done = 0;
    logic req_q = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (bif.AERIN_REQ && !req_q) begin
            addr_log[n_req % 512] = bif.AERIN_ADDR;
            n_req = n_req + 1;
        end
        req_q = bif.AERIN_REQ;
        if (done_o) n_done = n_done + 1;
    end

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr % 512] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; en_i = 1'b0; start_i = 1'b0; filter_done_i = 1'b0;
        #1;
        checks++; if (bif.AERIN_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bif.AERIN_REQ); end
        checks++; if (bif.AERIN_ADDR !== 17'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bif.AERIN_ADDR); end
        checks++; if (bif.FIFO_r_en_o !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b want 0", bif.FIFO_r_en_o); end
        checks++; if (evt_cnt_o !== 9'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", evt_cnt_o); end
        checks++; if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b want 00", {busy_o, done_o}); end
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single();
        int p0, r0, k;
        pulse_start();
        p0 = n_pops; r0 = n_req;
        en_i = 1'b1;
        push(8'h2A);
        k = 0;
        @(negedge CLK);
        while (!(evt_cnt_o == 9'd1 && !busy_o) && k < 100) begin @(negedge CLK); k++; end
        checks++; if (k >= 100) begin errors++; $display("FAIL single_timeout: got %0d cycles want <100", k); end
        @(negedge CLK);
        checks++; if (n_pops - p0 !== 1) begin errors++; $display("FAIL single_pops: got %0d want 1", n_pops - p0); end
        checks++; if (n_req - r0 !== 1) begin errors++; $display("FAIL single_reqs: got %0d want 1", n_req - r0); end
        checks++; if (addr_log[r0 % 512] !== 17'h02AFF) begin errors++; $display("FAIL single_addr: got %h want 02aff", addr_log[r0 % 512]); end
        checks++; if (evt_cnt_o !== 9'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", evt_cnt_o); end
        checks++; if (bif.AERIN_ADDR !== 17'h02AFF || bif.AERIN_REQ !== 1'b0) begin errors++; $display("FAIL single_hold: got addr %h req %b want 02aff 0", bif.AERIN_ADDR, bif.AERIN_REQ); end
    endtask

    task automatic test_burst();
        int r0, d0, k;
        logic [16:0] exp_addr [3];
        exp_addr[0] = 17'h003FF; exp_addr[1] = 17'h007FF; exp_addr[2] = 17'h0C8FF;
        pulse_start();
        r0 = n_req; d0 = n_done;
        push(8'd3); push(8'd7); push(8'd200);
        k = 0;
        while (bif.AERIN_REQ !== 1'b1 && k < 50) begin @(negedge CLK); k++; end
        filter_done_i = 1'b1;
        @(negedge CLK);
        filter_done_i = 1'b0;
        k = 0;
        while (done_o !== 1'b1 && k < 300) begin @(negedge CLK); k++; end
        checks++; if (k >= 300) begin errors++; $display("FAIL burst_done_timeout: got %0d cycles want <300", k); end
        checks++; if (evt_cnt_o !== 9'd3) begin errors++; $display("FAIL burst_cnt_at_done: got %0d want 3", evt_cnt_o); end
        checks++; if (n_req - r0 !== 3) begin errors++; $display("FAIL burst_reqs_at_done: got %0d want 3", n_req - r0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr_log[(r0 + i) % 512] !== exp_addr[i]) begin
                errors++; $display("FAIL burst_addr%0d: got %h want %h", i, addr_log[(r0 + i) % 512], exp_addr[i]);
            end
        end
        repeat (10) @(negedge CLK);
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL burst_done_count: got %0d want 1", n_done - d0); end
    endtask

    task automatic test_empty();
        int r0;
        pulse_start();
        r0 = n_req;
        @(negedge CLK);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL empty_pre_done: got %b want 0", done_o); end
        filter_done_i = 1'b1;
        @(negedge CLK);
        filter_done_i = 1'b0;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL empty_done: got %b want 1", done_o); end
        @(negedge CLK);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL empty_done_once: got %b want 0", done_o); end
        checks++; if (n_req - r0 !== 0 || evt_cnt_o !== 9'd0) begin errors++; $display("FAIL empty_no_evt: got reqs %0d cnt %0d want 0 0", n_req - r0, evt_cnt_o); end
    endtask

    task automatic test_en_drop();
        int p0, r0, k;
        pulse_start();
        p0 = n_pops; r0 = n_req;
        push(8'hA1); push(8'hB2);
        k = 0;
        while (bif.AERIN_REQ !== 1'b1 && k < 50) begin @(negedge CLK); k++; end
        en_i = 1'b0;
        k = 0;
        while (busy_o !== 1'b0 && k < 100) begin @(negedge CLK); k++; end
        checks++; if (k >= 100) begin errors++; $display("FAIL endrop_idle_timeout: got %0d cycles want <100", k); end
        checks++; if (evt_cnt_o !== 9'd1) begin errors++; $display("FAIL endrop_cnt: got %0d want 1", evt_cnt_o); end
        repeat (20) @(negedge CLK);
        checks++; if (n_pops - p0 !== 1 || (wr_ptr - rd_ptr) !== 1) begin errors++; $display("FAIL endrop_no_pop: got pops %0d level %0d want 1 1", n_pops - p0, wr_ptr - rd_ptr); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL endrop_busy: got %b want 0", busy_o); end
        en_i = 1'b1;
        k = 0;
        while (!(evt_cnt_o == 9'd2 && !busy_o) && k < 100) begin @(negedge CLK); k++; end
        checks++; if (evt_cnt_o !== 9'd2) begin errors++; $display("FAIL endrop_resume_cnt: got %0d want 2", evt_cnt_o); end
        checks++; if (addr_log[(r0 + 1) % 512] !== 17'h0B2FF) begin errors++; $display("FAIL endrop_resume_addr: got %h want 0b2ff", addr_log[(r0 + 1) % 512]); end
    endtask

    task automatic test_reset_mid();
        int k;
        pulse_start();
        push(8'h55); push(8'h66);
        k = 0;
        while (bif.AERIN_REQ !== 1'b1 && k < 50) begin @(negedge CLK); k++; end
        #2;
        RSTN = 1'b0;
        #1;
        checks++; if (bif.AERIN_REQ !== 1'b0) begin errors++; $display("FAIL rstmid_req_async: got %b want 0", bif.AERIN_REQ); end
        checks++; if ({bif.FIFO_r_en_o, busy_o, done_o, evt_cnt_o, bif.AERIN_ADDR} !== 29'h0) begin
            errors++; $display("FAIL rstmid_outputs: got ren %b busy %b done %b cnt %0d addr %h want all 0",
                               bif.FIFO_r_en_o, busy_o, done_o, evt_cnt_o, bif.AERIN_ADDR);
        end
        repeat (5) @(negedge CLK);
        RSTN = 1'b1;
        k = 0;
        while (!(evt_cnt_o == 9'd1 && !busy_o) && k < 100) begin @(negedge CLK); k++; end
        checks++; if (evt_cnt_o !== 9'd1) begin errors++; $display("FAIL rstmid_resume_cnt: got %0d want 1", evt_cnt_o); end
        checks++; if (bif.AERIN_ADDR !== 17'h066FF || bif.FIFO_empty_i !== 1'b1) begin errors++; $display("FAIL rstmid_resume_addr: got %h empty %b want 066ff 1", bif.AERIN_ADDR, bif.FIFO_empty_i); end
    endtask

    task automatic test_saturation();
        int r0, k;
        pulse_start();
        r0 = n_req;
        for (int i = 0; i < 259; i++) push(8'(i));
        k = 0;
        @(negedge CLK);
        while (!(bif.FIFO_empty_i && !busy_o) && k < 6000) begin @(negedge CLK); k++; end
        @(negedge CLK);
        checks++; if (k >= 6000) begin errors++; $display("FAIL sat_timeout: got %0d cycles want <6000", k); end
        checks++; if (n_req - r0 !== 259) begin errors++; $display("FAIL sat_reqs: got %0d want 259", n_req - r0); end
        checks++; if (evt_cnt_o !== 9'd256) begin errors++; $display("FAIL sat_cnt: got %0d want 256", evt_cnt_o); end
        pulse_start();
        checks++; if (evt_cnt_o !== 9'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", evt_cnt_o); end
        checks++; if (n_bad_pops !== 0) begin errors++; $display("FAIL pop_while_empty: got %0d want 0", n_bad_pops); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_empty();
        test_en_drop();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_dispatcher.md
Name: spike_dispatcher

Overview:
- Consumer end of the spike FIFO that the spike filter writes into.
- Pops M-bit input-neuron indices from the FIFO and delivers each one to the tinyODIN core as an AER event, using a 4-phase req/ack handshake.
- Counts dispatched events per tick.
- Signals tick completion once the filter has finished and the FIFO has drained.

Parameters:
- N, 256, number of input neurons; sets the event-counter width.
- M, 8, neuron-index width; equals FIFO data width.
- EVT_CODE, 8'hFF, M-bit code placed in the AER address LSBs to mark a virtual input spike.

Ports:
- CLK  input  1  clock.
- RSTN  input  1  asynchronous active-low reset.
- en_i  input  1  dispatch enable; level signal.
- start_i  input  1  tick-start pulse; clears the event counter and pending-done.
- filter_done_i  input  1  pulse: filter has finished scanning for this tick.
- FIFO_r_en_o  output  1  FIFO pop strobe.
- FIFO_r_data_i  input  M  FIFO read data, valid the cycle after FIFO_r_en_o.
- FIFO_empty_i  input  1  FIFO empty flag.
- AERIN_ADDR  output  2M+1  AER event address.
- AERIN_REQ  output  1  AER request.
- AERIN_ACK  input  1  AER acknowledge; asynchronous to CLK.
- evt_cnt_o  output  $clog2(N)+1  events completed since the last start_i.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle tick-complete pulse.

Behaviour:
- Reset (async, RSTN low): state=IDLE; FIFO_r_en_o=0; AERIN_REQ=0; AERIN_ADDR=0; evt_cnt_o=0; busy_o=0; done_o=0; ack synchroniser flops=0; pending_done=0.
- Reset asserted mid-handshake drops AERIN_REQ immediately. No event is counted.
- AERIN_ACK passes through a 2-flop synchroniser; ack_s is the second flop. All FSM decisions use ack_s only.
- AERIN_REQ, AERIN_ADDR, FIFO_r_en_o, busy_o and done_o are registered outputs.
- FSM states:
  - IDLE: if en_i && !FIFO_empty_i -> POP.
  - POP: FIFO_r_en_o=1 for exactly this one cycle -> LOAD.
  - LOAD: capture AERIN_ADDR <= {1'b0, FIFO_r_data_i, EVT_CODE} -> REQ.
  - REQ: AERIN_REQ=1; hold until ack_s==1 -> REL.
  - REL: AERIN_REQ=0; hold until ack_s==0. On exit, evt_cnt_o increments.
    - Then: if en_i && !FIFO_empty_i -> POP; else -> IDLE.
- AERIN_ADDR is stable from LOAD through the end of REL. It is not cleared between events.
- Minimum cost per event with ack responding immediately: POP(1) + LOAD(1) + REQ (>=3, synchroniser) + REL (>=3) = 8 cycles.
- en_i deasserted mid-event: the current handshake completes and is counted. The FSM then returns to IDLE and pops nothing further.
- FIFO_empty_i is sampled only in IDLE and REL. The FIFO never pops while empty.
- evt_cnt_o:
  - Cleared to 0 on start_i; start_i has priority over a same-cycle increment.
  - Saturates at N; never wraps.
- pending_done:
  - Set by filter_done_i; cleared by start_i (start_i wins if both are asserted in the same cycle).
  - done_o pulses for 1 cycle when pending_done && state==IDLE && FIFO_empty_i. pending_done clears in the same cycle.
  - If filter_done_i arrives while the FIFO is already empty and the FSM is in IDLE, done_o asserts the following cycle.
- start_i during an active handshake does not abort it. The counter restarts from 0, and the in-flight event is counted into the new tick.
- AERIN_ACK high while in IDLE, POP or LOAD is ignored. REQ waits for ack_s high, so a stuck-high ack completes REQ but then stalls in REL.

Test Plan:
- Single event:
  - Stimulus: FIFO holds 8'h2A, en_i=1, ack model responds 2 cycles after each req edge.
  - Required response: one FIFO_r_en_o pulse; AERIN_ADDR=17'h02AFF; REQ rises and falls once; evt_cnt_o=1.
- Burst drain:
  - Stimulus: FIFO holds 3,7,200; filter_done_i pulsed during the first event.
  - Required response: addresses 17'h003FF, 17'h007FF, 17'h0C8FF in order; evt_cnt_o=3; done_o pulses exactly once, after the third REL exits.
- Empty tick:
  - Stimulus: start_i, then filter_done_i with the FIFO empty.
  - Required response: no REQ; done_o pulses 1 cycle later; evt_cnt_o=0.
- Enable drop:
  - Stimulus: en_i falls while in REQ with 2 entries queued.
  - Required response: current handshake completes; evt_cnt_o=1; FSM returns to IDLE; second entry not popped until en_i=1.
- Reset mid-handshake:
  - Stimulus: RSTN low while AERIN_REQ=1.
  - Required response: AERIN_REQ=0 asynchronously; all outputs at their reset values; after release, pending FIFO data is dispatched normally.
- Saturation:
  - Stimulus: N+3=259 events in one tick (FIFO refilled).
  - Required response: evt_cnt_o holds 256; next start_i clears it to 0.
